// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable counter: count modes and controller states.
package prog_counter_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_PRESCALE_W = 4;

  // Mode encoding 2'd3 is reserved and behaves like MODE_WRAP.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/prog_counter_if.sv
// Control and status bundle of prog_counter; master drives controls, slave is the counter.
interface prog_counter_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) ();

  logic                  en;
  logic                  start;
  logic                  stop;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      limit;
  logic                  up;
  logic [1:0]            mode;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic                  busy;
  logic                  done;

  modport master (
    output en, start, stop, load, load_val, limit, up, mode, prescale,
    input  count, tc, busy, done
  );

  modport slave (
    input  en, start, stop, load, load_val, limit, up, mode, prescale,
    output count, tc, busy, done
  );

endinterface

// File: rtl/prog_counter_tick_gen.sv
// Prescaler: emits one tick every prescale+1 enabled running cycles.
module tick_gen #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] r_pre_cnt;

  // Using >= keeps the divider from running away when prescale shrinks mid-count.
  assign tick = run && en && (r_pre_cnt >= prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt <= '0;
    end else if (clear) begin
      r_pre_cnt <= '0;
    end else if (run && en) begin
      r_pre_cnt <= tick ? '0 : r_pre_cnt + ONE;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler, load, terminal-count pulse and
// wrap / saturate / one-shot modes.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic         clk,
  input  logic         rst,
  prog_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic             r_tc;
  logic             w_tc_next;
  logic             w_tick;
  logic             w_clear;
  logic             w_run;
  logic             w_terminal;
  logic [WIDTH-1:0] w_reload;

  assign w_run      = (r_state == ST_RUN);
  assign w_terminal = bus.up ? (r_count >= bus.limit) : (r_count == '0);
  assign w_reload   = bus.up ? '0 : bus.limit;

  tick_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .run      (w_run),
    .en       (bus.en),
    .clear    (w_clear),
    .prescale (bus.prescale),
    .tick     (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_tc    <= w_tc_next;
    end
  end

  // Priority chain: load > stop > start > tick; a start while running is ignored.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_tc_next    = 1'b0;
    w_clear      = 1'b0;
    if (bus.load) begin
      w_count_next = bus.load_val;
      w_clear      = 1'b1;
    end else if (bus.stop) begin
      w_state_next = ST_IDLE;
    end else if (bus.start && (r_state != ST_RUN)) begin
      w_state_next = ST_RUN;
      w_clear      = 1'b1;
      if (r_state == ST_DONE) begin
        w_count_next = w_reload;
      end
    end else if (w_tick) begin
      if (w_terminal) begin
        w_tc_next = 1'b1;
        if (bus.mode == MODE_ONESHOT) begin
          w_state_next = ST_DONE;
        end else if (bus.mode != MODE_SAT) begin
          w_count_next = w_reload;
        end
      end else begin
        w_count_next = bus.up ? (r_count + ONE) : (r_count - ONE);
      end
    end
  end

  assign bus.count = r_count;
  assign bus.tc    = r_tc;
  assign bus.busy  = (r_state == ST_RUN);
  assign bus.done  = (r_state == ST_DONE);

endmodule
